// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS datapath definitions: ALU_Control codes, register-specifier width,
// and the operand forwarding-select type used by the ID/EX stage.
package id_ex_stage_pkg;

  localparam int REG_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [1:0] {
    REG = 2'd0,
    EXM = 2'd1,
    WB  = 2'd2
  } fwd_sel_e;

  // EX/MEM is the younger producer, so it wins over MEM/WB; $0 never forwards.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_W-1:0] spec,
    input logic             exm_regwrite,
    input logic [REG_W-1:0] exm_rd,
    input logic             wb_regwrite,
    input logic [REG_W-1:0] wb_rd
  );
    if (exm_regwrite && (exm_rd != '0) && (exm_rd == spec))
      return EXM;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == spec))
      return WB;
    else
      return REG;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, forwarding-side and EX-side signal bundle of the ID/EX stage.
// The slave modport is the stage itself; master is whoever drives decode.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int W = 32
) ();

  logic             stall;
  logic             flush;
  logic [W-1:0]     id_rd1;
  logic [W-1:0]     id_rd2;
  logic [W-1:0]     id_imm;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic [REG_W-1:0] id_shamt;
  logic [3:0]       id_alu_ctl;
  logic             id_alusrc;
  logic             id_regdst;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memwrite;
  logic             id_memtoreg;
  logic             exm_regwrite;
  logic [REG_W-1:0] exm_rd;
  logic [W-1:0]     exm_result;
  logic             wb_regwrite;
  logic [REG_W-1:0] wb_rd;
  logic [W-1:0]     wb_data;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [3:0]       alu_ctl;
  logic [REG_W-1:0] alu_shamt;
  logic [W-1:0]     ex_store_data;
  logic [REG_W-1:0] ex_dst;
  logic             ex_regwrite;
  logic             ex_memread;
  logic             ex_memwrite;
  logic             ex_memtoreg;
  logic             ex_valid;
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;

  modport slave (
    input  stall, flush,
    input  id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_shamt, id_alu_ctl,
    input  id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg,
    input  exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_data,
    output alu_a, alu_b, alu_ctl, alu_shamt, ex_store_data, ex_dst,
    output ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_valid, ex_rs, ex_rt
  );

  modport master (
    output stall, flush,
    output id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_shamt, id_alu_ctl,
    output id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg,
    output exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_data,
    input  alu_a, alu_b, alu_ctl, alu_shamt, ex_store_data, ex_dst,
    input  ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_valid, ex_rs, ex_rt
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: picks EX/MEM result, MEM/WB data or the registered
// read value for one source register specifier.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [REG_W-1:0] spec,
  input  logic [W-1:0]     reg_val,
  input  logic             exm_regwrite,
  input  logic [REG_W-1:0] exm_rd,
  input  logic [W-1:0]     exm_result,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [W-1:0]     wb_data,
  output logic [W-1:0]     val
);

  fwd_sel_e sel;

  always_comb begin
    sel = fwd_select(spec, exm_regwrite, exm_rd, wb_regwrite, wb_rd);
    val = reg_val;
    case (sel)
      EXM:     val = exm_result;
      WB:      val = wb_data;
      default: val = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, plus same-cycle operand forwarding
// and ALU source selection on the registered instruction.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int W = 32
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  logic [W-1:0]     rd1_p1;
  logic [W-1:0]     rd2_p1;
  logic [W-1:0]     imm_p1;
  logic [REG_W-1:0] rs_p1;
  logic [REG_W-1:0] rt_p1;
  logic [REG_W-1:0] dst_p1;
  logic [REG_W-1:0] shamt_p1;
  logic [3:0]       ctl_p1;
  logic             alusrc_p1;
  logic             regwrite_p1;
  logic             memread_p1;
  logic             memwrite_p1;
  logic             memtoreg_p1;
  logic             vld_p1;
  logic [W-1:0]     fwd_a_p1;
  logic [W-1:0]     fwd_b_p1;

  // ---- ID -> EX register: reset > flush (bubble) > stall (hold) > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.flush) begin
      rd1_p1      <= '0;
      rd2_p1      <= '0;
      imm_p1      <= '0;
      rs_p1       <= '0;
      rt_p1       <= '0;
      dst_p1      <= '0;
      shamt_p1    <= '0;
      ctl_p1      <= ALU_AND;
      alusrc_p1   <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      vld_p1      <= 1'b0;
    end else if (!bus.stall) begin
      rd1_p1      <= bus.id_rd1;
      rd2_p1      <= bus.id_rd2;
      imm_p1      <= bus.id_imm;
      rs_p1       <= bus.id_rs;
      rt_p1       <= bus.id_rt;
      dst_p1      <= bus.id_regdst ? bus.id_rd : bus.id_rt;
      shamt_p1    <= bus.id_shamt;
      ctl_p1      <= bus.id_alu_ctl;
      alusrc_p1   <= bus.id_alusrc;
      regwrite_p1 <= bus.id_regwrite;
      memread_p1  <= bus.id_memread;
      memwrite_p1 <= bus.id_memwrite;
      memtoreg_p1 <= bus.id_memtoreg;
      vld_p1      <= 1'b1;
    end
  end

  // ---- EX: combinational forwarding from the live EX/MEM and MEM/WB ports
  fwd_mux #(.W(W)) u_fwd_a (
    .spec         (rs_p1),
    .reg_val      (rd1_p1),
    .exm_regwrite (bus.exm_regwrite),
    .exm_rd       (bus.exm_rd),
    .exm_result   (bus.exm_result),
    .wb_regwrite  (bus.wb_regwrite),
    .wb_rd        (bus.wb_rd),
    .wb_data      (bus.wb_data),
    .val          (fwd_a_p1)
  );

  fwd_mux #(.W(W)) u_fwd_b (
    .spec         (rt_p1),
    .reg_val      (rd2_p1),
    .exm_regwrite (bus.exm_regwrite),
    .exm_rd       (bus.exm_rd),
    .exm_result   (bus.exm_result),
    .wb_regwrite  (bus.wb_regwrite),
    .wb_rd        (bus.wb_rd),
    .wb_data      (bus.wb_data),
    .val          (fwd_b_p1)
  );

  assign bus.alu_a         = fwd_a_p1;
  assign bus.alu_b         = alusrc_p1 ? imm_p1 : fwd_b_p1;
  assign bus.ex_store_data = fwd_b_p1;
  assign bus.alu_ctl       = ctl_p1;
  assign bus.alu_shamt     = shamt_p1;
  assign bus.ex_dst        = dst_p1;
  assign bus.ex_regwrite   = regwrite_p1;
  assign bus.ex_memread    = memread_p1;
  assign bus.ex_memwrite   = memwrite_p1;
  assign bus.ex_memtoreg   = memtoreg_p1;
  assign bus.ex_valid      = vld_p1;
  assign bus.ex_rs         = rs_p1;
  assign bus.ex_rt         = rt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: the driver queues hand-computed expected
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [3:0]  ctl;
    logic [4:0]  shamt;
    logic [4:0]  dst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mtr;
    logic        v;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  string name_q[$];
  int checks;
  int errors;

  id_ex_stage_if #(.W(32)) bus ();

  id_ex_stage #(.W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: checks=%0d pending=%0d", checks, exp_q.size());
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(
    input logic [31:0] a, b, st,
    input logic [3:0]  ctl,
    input logic [4:0]  shamt, dst, rs, rt,
    input logic        rw, mr, mw, mtr, v
  );
    exp_t e;
    e.a = a; e.b = b; e.st = st; e.ctl = ctl; e.shamt = shamt; e.dst = dst;
    e.rs = rs; e.rt = rt; e.rw = rw; e.mr = mr; e.mw = mw; e.mtr = mtr; e.v = v;
    return e;
  endfunction

  task automatic expect_out(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic set_id(
    input logic [31:0] rd1, rd2, imm,
    input logic [4:0]  rs, rt, rd, shamt,
    input logic [3:0]  ctl,
    input logic        alusrc, regdst, regwrite, memread, memwrite, memtoreg
  );
    bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_imm = imm;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.id_shamt = shamt;
    bus.id_alu_ctl = ctl; bus.id_alusrc = alusrc; bus.id_regdst = regdst;
    bus.id_regwrite = regwrite; bus.id_memread = memread;
    bus.id_memwrite = memwrite; bus.id_memtoreg = memtoreg;
  endtask

  task automatic set_fwd(
    input logic exm_rw, input logic [4:0] exm_rd, input logic [31:0] exm_res,
    input logic wb_rw, input logic [4:0] wb_rd, input logic [31:0] wb_dat
  );
    bus.exm_regwrite = exm_rw; bus.exm_rd = exm_rd; bus.exm_result = exm_res;
    bus.wb_regwrite = wb_rw; bus.wb_rd = wb_rd; bus.wb_data = wb_dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the DUT at the falling edge.
  initial begin
    exp_t act;
    exp_t e;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = mk(bus.alu_a, bus.alu_b, bus.ex_store_data, bus.alu_ctl, bus.alu_shamt,
                 bus.ex_dst, bus.ex_rs, bus.ex_rt, bus.ex_regwrite, bus.ex_memread,
                 bus.ex_memwrite, bus.ex_memtoreg, bus.ex_valid);
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got a=%h b=%h st=%h ctl=%h sh=%0d dst=%0d rs=%0d rt=%0d rw/mr/mw/mtr/v=%b%b%b%b%b expected a=%h b=%h st=%h ctl=%h sh=%0d dst=%0d rs=%0d rt=%0d rw/mr/mw/mtr/v=%b%b%b%b%b",
                   nm, act.a, act.b, act.st, act.ctl, act.shamt, act.dst, act.rs, act.rt,
                   act.rw, act.mr, act.mw, act.mtr, act.v,
                   e.a, e.b, e.st, e.ctl, e.shamt, e.dst, e.rs, e.rt,
                   e.rw, e.mr, e.mw, e.mtr, e.v);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id('0, '0, '0, '0, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, '0, '0, 0, '0, '0);
    expect_out("reset_idle", '0);

    // Reset must dominate even with a live instruction on the decode side
    step();
    set_id(32'd5, 32'd7, 32'h10, 5'd1, 5'd2, 5'd3, 5'd0, ALU_ADD, 0, 1, 1, 0, 0, 0);
    expect_out("reset_hold", '0);
    step();
    reset = 1'b0;

    step();
    expect_out("add_load", mk(32'd5, 32'd7, 32'd7, ALU_ADD, 5'd0, 5'd3, 5'd1, 5'd2, 1, 0, 0, 0, 1));
    set_id(32'h99, 32'h77, 32'h0, 5'd4, 5'd5, 5'd6, 5'd0, ALU_ADD, 0, 1, 1, 0, 0, 0);

    step();
    set_fwd(1, 5'd4, 32'h11, 1, 5'd4, 32'h22);
    expect_out("fwd_exm_beats_wb", mk(32'h11, 32'h77, 32'h77, ALU_ADD, 5'd0, 5'd6, 5'd4, 5'd5, 1, 0, 0, 0, 1));
    bus.stall = 1'b1;

    step();
    set_fwd(1, 5'd9, 32'h11, 1, 5'd4, 32'h22);
    expect_out("fwd_wb_in_stall", mk(32'h22, 32'h77, 32'h77, ALU_ADD, 5'd0, 5'd6, 5'd4, 5'd5, 1, 0, 0, 0, 1));
    bus.stall = 1'b0;
    set_id(32'h0, 32'h33, 32'h0, 5'd0, 5'd2, 5'd9, 5'd0, ALU_OR, 0, 0, 1, 0, 0, 0);

    step();
    set_fwd(1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE);
    expect_out("no_fwd_r0", mk(32'h0, 32'h33, 32'h33, ALU_OR, 5'd0, 5'd2, 5'd0, 5'd2, 1, 0, 0, 0, 1));
    set_id(32'h100, 32'h5, 32'hFFFFFFFC, 5'd8, 5'd9, 5'd0, 5'd0, ALU_ADD, 1, 0, 0, 0, 1, 0);

    step();
    set_fwd(0, 5'd9, 32'h44, 1, 5'd9, 32'hAB);
    expect_out("sw_imm_store_fwd", mk(32'h100, 32'hFFFFFFFC, 32'hAB, ALU_ADD, 5'd0, 5'd9, 5'd8, 5'd9, 0, 0, 1, 0, 1));
    set_id(32'h0, 32'h80000000, 32'h0, 5'd0, 5'd10, 5'd11, 5'd4, ALU_SRA, 0, 1, 1, 0, 0, 0);

    step();
    set_fwd(0, '0, '0, 0, '0, '0);
    expect_out("sra_passthru", mk(32'h0, 32'h80000000, 32'h80000000, ALU_SRA, 5'd4, 5'd11, 5'd0, 5'd10, 1, 0, 0, 0, 1));
    set_id(32'h2000, 32'h1, 32'h8, 5'd12, 5'd13, 5'd14, 5'd0, ALU_ADD, 1, 0, 1, 1, 0, 1);

    step();
    set_fwd(1, 5'd13, 32'h55, 1, 5'd13, 32'h66);
    expect_out("lw_rt_fwd", mk(32'h2000, 32'h8, 32'h55, ALU_ADD, 5'd0, 5'd13, 5'd12, 5'd13, 1, 1, 0, 1, 1));
    bus.stall = 1'b1;
    set_id(32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 5'd4, ALU_OR, 1, 1, 0, 0, 1, 0);

    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("stall_hold_%0d", i),
                 mk(32'h2000, 32'h8, 32'h55, ALU_ADD, 5'd0, 5'd13, 5'd12, 5'd13, 1, 1, 0, 1, 1));
      set_id(32'h10 + i, 32'h20 + i, 32'h30 + i, 5'd21, 5'd22, 5'd23, 5'd1, ALU_NOR, 0, 1, 1, 1, 1, 1);
    end
    bus.flush = 1'b1;

    step();
    expect_out("flush_with_stall", '0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    set_id(32'h1234, 32'h1234, 32'h0, 5'd3, 5'd3, 5'd20, 5'd0, ALU_XOR, 0, 1, 1, 0, 0, 0);

    step();
    set_fwd(0, 5'd3, 32'h99, 1, 5'd3, 32'hCAFE);
    expect_out("fwd_both_wb", mk(32'hCAFE, 32'hCAFE, 32'hCAFE, ALU_XOR, 5'd0, 5'd20, 5'd3, 5'd3, 1, 0, 0, 0, 1));
    set_id(32'h7, 32'h8, 32'h9, 5'd1, 5'd2, 5'd3, 5'd2, ALU_SLL, 0, 1, 1, 0, 0, 0);

    // Reset raised between edges must clear the outputs before the next edge
    step();
    set_fwd(0, '0, '0, 0, '0, '0);
    reset = 1'b1;
    expect_out("async_reset", '0);
    set_id(32'hA, 32'hB, 32'h0, 5'd5, 5'd6, 5'd7, 5'd0, ALU_SUB, 0, 1, 1, 0, 0, 0);
    step();
    reset = 1'b0;

    step();
    expect_out("post_reset_load", mk(32'hA, 32'hB, 32'hB, ALU_SUB, 5'd0, 5'd7, 5'd5, 5'd6, 1, 0, 0, 0, 1));

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and operand-selection stage for the ID/EX boundary of the 5-stage MIPS datapath. Captures decoded operands, register specifiers and control from decode each cycle. Presents the ALU with forwarded, source-selected operands (Data1, Data2, ALU_Control, Shamt) and passes the destination register and memory/writeback control on to EX/MEM. Supports hold (stall) and bubble insertion (flush).

## Interface
- `W`, default 32: datapath width.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `stall`, input, 1: hold every register this cycle.
- `flush`, input, 1: load a bubble this cycle.
- `id_rd1`, `id_rd2`, input, W: register-file read data for rs and rt.
- `id_imm`, input, W: sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`, input, 5 each: register specifiers.
- `id_shamt`, input, 5: shift amount.
- `id_alu_ctl`, input, 4: ALU operation code.
- `id_alusrc`, `id_regdst`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg`, input, 1 each: decoded control.
- `exm_regwrite`, input, 1: EX/MEM stage writes a register.
- `exm_rd`, input, 5: EX/MEM destination register.
- `exm_result`, input, W: EX/MEM forwarded value.
- `wb_regwrite`, input, 1: MEM/WB stage writes a register.
- `wb_rd`, input, 5: MEM/WB destination register.
- `wb_data`, input, W: MEM/WB forwarded value.
- `alu_a`, `alu_b`, output, W: ALU Data1 and Data2.
- `alu_ctl`, output, 4: ALU_Control.
- `alu_shamt`, output, 5: ALU Shamt.
- `ex_store_data`, output, W: forwarded rt value, used as memory write data.
- `ex_dst`, output, 5: destination register (rd if regdst=1, else rt).
- `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_memtoreg`, output, 1 each: registered control.
- `ex_valid`, output, 1: stage holds a real instruction.
- `ex_rs`, `ex_rt`, output, 5: registered specifiers, for hazard detection.

## Operation
- Register update priority: `reset` > `flush` > `stall` > load.
- `reset`: all registered fields go to 0, so every output reads 0. `alu_ctl` reads 4'b0000 (AND of 0,0 gives result 0).
- `flush`: loads a bubble.
  - `ex_valid`, `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_memtoreg` go to 0.
  - Data, specifier and ALU-control fields also go to 0.
- `stall` (without flush): all registers hold their values.
- Load: every `id_*` field is captured. `ex_valid` is set to 1.
- `ex_dst` is registered, and is selected from `id_rd`/`id_rt` by `id_regdst` at capture.
- Forwarding is combinational from the registered `rs`/`rt` and the live `exm_*`/`wb_*` inputs. For operand A (rs); B-source uses rt the same way:
  - Use `exm_result` if `exm_regwrite` and `exm_rd`≠0 and `exm_rd`==rs.
  - Otherwise use `wb_data` if `wb_regwrite` and `wb_rd`≠0 and `wb_rd`==rs.
  - Otherwise use the registered `rd1`.
  - EX/MEM always beats MEM/WB when both match.
- Operand B:
  - `alu_b` = registered imm if alusrc=1, else the forwarded rt value.
  - `ex_store_data` = the forwarded rt value regardless of alusrc.
- Register $0 is never forwarded. The registered read value is used as-is.
- Shift operands pass through unchanged. The ALU takes the shifted operand from Data2 and the amount from `alu_shamt`.

## Timing
- Latency: decode inputs sampled at edge N appear on the outputs after edge N.
- Forwarding path: zero-cycle (same-cycle combinational) from `exm_*`/`wb_*` to `alu_a`/`alu_b`/`ex_store_data`.
- `stall` held for k cycles keeps the outputs frozen for k cycles. Forwarded operands can still change during a stall if the `exm_*`/`wb_*` inputs change.
- `flush` and `stall` asserted together: bubble is loaded.
- `reset` asserted mid-stream, asynchronously: outputs clear immediately, without waiting for a clock. The first load happens on the first rising edge after `reset` deasserts.
- No internal FSM. The only state is the pipeline register plus the `ex_valid` bit.

## Structure
- The shared MIPS package holds:
  - ALU_Control encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1010, SRA 1011, NOR 1100, XOR 1101.
  - Register-specifier width (5).
  - The forwarding-select enum: REG, EXM, WB.
- One natural sub-module: `fwd_mux`, instantiated twice (rs and rt). Inputs: specifier, registered value, exm/wb triples. Output: selected value.

## Test plan
- Reset then idle → all outputs 0, `ex_valid`=0. Assert `reset` mid-load → outputs go to 0 before the next edge.
- Load ADD with rd1=5, rd2=7, alusrc=0, rd=3, regdst=1 → next cycle: `alu_a`=5, `alu_b`=7, `alu_ctl`=0010, `ex_dst`=3, `ex_valid`=1.
- rs=4, `exm_regwrite`=1, `exm_rd`=4, `exm_result`=0x11; also `wb_rd`=4, `wb_data`=0x22 → `alu_a`=0x11. Drop the EXM match → `alu_a`=0x22.
- rs=0, `exm_rd`=0, `exm_regwrite`=1, `exm_result`=0xFF, rd1=0 → `alu_a`=0 (no forwarding of $0).
- SW with alusrc=1, imm=0xFFFFFFFC, rt forwarded from WB with value 0xAB → `alu_b`=0xFFFFFFFC, `ex_store_data`=0xAB, `ex_memwrite`=1.
- Stall for 3 cycles with changing `id_*` → outputs unchanged. `flush`+`stall` together → `ex_valid`=0, `ex_regwrite`=0, `ex_memwrite`=0 on the next cycle.
